id_stage_param: RTL and testbench
=================================

Name: id_stage_param

Overview:
- Parametrised decode stage with integrated register file, for XLEN=32/64 and RV-I/RV-E register counts.
- Decodes one instruction per cycle into operands, fields and a sign-extended immediate. Presents them through a valid/ready pipeline register to EX.
- Accepts writeback with write-through bypass, and refreshes held operands while stalled.
- Sits between IF and EX; the writeback port is driven from WB.

Parameters:
- XLEN, 64, datapath/register width; legal 32 or 64.
- NUM_REGS, 32, architectural registers; legal 16 or 32.
- NOP_OPCODE, 7'b0010011, opcode driven on out_opcode when the stage is empty or reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  kill stage contents.
- in_valid  in  1  IF has an instruction.
- in_ready  out  1  stage accepts this cycle.
- inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EX accepts the bundle.
- out_opcode  out  7  inst[6:0].
- out_rd  out  5  inst[11:7].
- out_func3  out  3  inst[14:12].
- out_func7  out  7  inst[31:25].
- out_rs1_data  out  XLEN  rs1 operand.
- out_rs2_data  out  XLEN  rs2 operand.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  PC of the bundle.
- out_illegal  out  1  unknown opcode, or register index >= NUM_REGS.
- wb_en  in  1  writeback strobe.
- wb_rd  in  5  writeback register.
- wb_data  in  XLEN  writeback value.
- dbg_raddr  in  5  debug read address.
- dbg_rdata  out  XLEN  debug read data (bypassed, combinational).

Behaviour:
- Reset (synchronous, dominates flush):
  - All registers and output fields 0, except out_opcode=NOP_OPCODE.
  - out_valid=0; scoreboard cleared.
- Register file:
  - Writes on posedge when wb_en, wb_rd!=0 and wb_rd<NUM_REGS; other writes are ignored.
  - Index 0 always reads 0. Indices >= NUM_REGS read 0.
  - Read bypass: if wb_en, wb_rd==src and src!=0, read data = wb_data in the same cycle. The same bypass applies to dbg_rdata.
- Handshake:
  - in_ready = !flush & (!out_valid | out_ready) & !sb_stall (sb_stall=0 without the option).
  - Transfer on in_valid & in_ready: decoded bundle registered, out_valid=1 next cycle. Latency 1 cycle.
  - out_valid & !out_ready: all out_* held stable, except operand refresh below.
  - Bundle consumed with no new transfer: out_valid->0 and out_opcode->NOP_OPCODE; other fields don't-care.
- Operand refresh: while a bundle is held and wb_en targets a held source index (nonzero), the matching out_rsN_data takes wb_data next cycle.
- Flush:
  - Next cycle out_valid=0 and out_opcode=NOP_OPCODE.
  - The input offered in the flush cycle is not accepted.
  - Register writes in the flush cycle still occur.
- Immediates (sign-extended from inst[31] to XLEN):
  - I-type 0010011/0000011/1100111: inst[31:20].
  - S-type 0100011: {inst[31:25], inst[11:7]}.
  - B-type 1100011: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type 0110111/0010111: {inst[31:12], 12'b0}, sign-extended when XLEN=64.
  - J-type 1101111: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type 0110011 and others: 0.
- out_illegal is set for:
  - any opcode outside the above list, plus 0111011 (when XLEN=64) and 0011011;
  - any used rs1/rs2/rd index >= NUM_REGS.
  - Illegal bundles still flow.
- Writing instructions: every opcode except store (0100011) and branch (1100011), with rd!=0.

Optional Feature:
- Macro ID_SCOREBOARD_EN.
- Defined:
  - NUM_REGS-bit pending vector. A transfer of a writing instruction sets pending[rd]. wb_en clears pending[wb_rd].
  - Set wins over clear for the same index in the same cycle.
  - sb_stall=1 when in_valid and inst's used rs1 or rs2 is pending and not cleared by this cycle's wb.
  - flush and rst clear all pending bits; the pipeline guarantees no older write is outstanding when flush asserts.
- Undefined: no pending state, sb_stall tied 0; hazards are the pipeline's responsibility.

Test Plan:
- rst=1 for 2 cycles, then inst=0x00500093 (addi x1,x0,5), in_valid=1, out_ready=1 -> next cycle:
  - out_valid=1, out_opcode=0010011, out_rd=1, out_imm=5, out_rs1_data=0.
- wb_en=1 wb_rd=3 wb_data=0xABCD in the same cycle as decode of add x4,x3,x3 -> out_rs1_data=out_rs2_data=0xABCD.
- out_ready=0 holding add x5,x6,x0; pulse wb x6=0x77 -> next cycle:
  - out_rs1_data=0x77; other fields unchanged; in_ready=0 throughout.
- inst=0xFE000EE3 (beq, imm -4) with XLEN=64 -> out_imm=0xFFFF_FFFF_FFFF_FFFC.
- flush=1 with in_valid=1 and a valid bundle held -> in_ready=0, next cycle out_valid=0, out_opcode=0010011.
- ID_SCOREBOARD_EN:
  - lw x7 accepted, then add x8,x7,x0 offered -> in_ready=0 until wb_en wb_rd=7.
  - Accepted in the wb cycle with bypassed data.

Source files
------------

// File: rtl/id_stage_param.sv
// id_stage_param: decode stage with register file, write-through bypass and a valid/ready output register.
// Optional operand scoreboard enabled by defining ID_SCOREBOARD_EN.
module id_stage_param #(
    parameter int         XLEN       = 64,
    parameter int         NUM_REGS   = 32,
    parameter logic [6:0] NOP_OPCODE = 7'b0010011
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);
    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0] regs [NUM_REGS];
    logic [6:0]      op;
    logic [4:0]      rs1, rs2, rd, hold_rs1, hold_rs2;
    logic            is_i, is_s, is_b, is_u, is_j, is_r, is_wi, is_wr;
    logic            legal, use_rs1, use_rs2, use_rd, illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm, rs1_val, rs2_val;
    logic            wb_hit, xfer, sb_stall;

    function automatic logic idx_ok(input logic [4:0] a);
        return NUM_REGS == 32 || !a[4];
    endfunction

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
        if (wb_hit && wb_rd == a)
            return wb_data;
        return (a == 5'd0 || !idx_ok(a)) ? '0 : regs[a[AW-1:0]];
    endfunction

    assign wb_hit    = wb_en && wb_rd != 5'd0 && idx_ok(wb_rd);
    assign rs1_val   = rf_read(rs1);
    assign rs2_val   = rf_read(rs2);
    assign dbg_rdata = rf_read(dbg_raddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_rd[AW-1:0]] <= wb_data;
        end
    end

    assign op  = inst[6:0];
    assign rd  = inst[11:7];
    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    assign is_i  = op inside {7'b0010011, 7'b0000011, 7'b1100111};
    assign is_s  = op == 7'b0100011;
    assign is_b  = op == 7'b1100011;
    assign is_u  = op inside {7'b0110111, 7'b0010111};
    assign is_j  = op == 7'b1101111;
    assign is_r  = op == 7'b0110011;
    assign is_wi = op == 7'b0011011;
    assign is_wr = op == 7'b0111011;

    assign legal   = is_i || is_s || is_b || is_u || is_j || is_r || is_wi || (is_wr && XLEN == 64);
    assign use_rs1 = is_i || is_s || is_b || is_r || is_wi || is_wr;
    assign use_rs2 = is_s || is_b || is_r || is_wr;
    assign use_rd  = !(is_s || is_b);
    assign illegal = !legal || (use_rs1 && !idx_ok(rs1)) || (use_rs2 && !idx_ok(rs2)) ||
                     (use_rd && !idx_ok(rd));

    assign imm32 = is_i ? {{20{inst[31]}}, inst[31:20]} :
                   is_s ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                   is_b ? {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                   is_u ? {inst[31:12], 12'b0} :
                   is_j ? {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} : '0;
    assign imm = XLEN'($signed(imm32));

`ifdef ID_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pending, clr_vec, set_vec, live;
    logic                writes;

    assign writes = use_rd && rd != 5'd0;

    always_comb begin
        clr_vec = '0;
        if (wb_en && idx_ok(wb_rd))
            clr_vec[wb_rd[AW-1:0]] = 1'b1;
    end

    always_comb begin
        set_vec = '0;
        if (xfer && writes && idx_ok(rd))
            set_vec[rd[AW-1:0]] = 1'b1;
    end

    // A writeback landing this cycle releases its register before the hazard test.
    assign live     = pending & ~clr_vec;
    assign sb_stall = in_valid && ((use_rs1 && idx_ok(rs1) && live[rs1[AW-1:0]]) ||
                                   (use_rs2 && idx_ok(rs2) && live[rs2[AW-1:0]]));

    always_ff @(posedge clk)
        pending <= (rst || flush) ? '0 : live | set_vec;
`else
    assign sb_stall = 1'b0;
`endif

    assign in_ready = !flush && (!out_valid || out_ready) && !sb_stall;
    assign xfer     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_opcode   <= NOP_OPCODE;
            out_rd       <= '0;
            out_func3    <= '0;
            out_func7    <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            out_pc       <= '0;
            out_illegal  <= 1'b0;
            hold_rs1     <= '0;
            hold_rs2     <= '0;
        end else if (xfer) begin
            out_valid    <= 1'b1;
            out_opcode   <= op;
            out_rd       <= rd;
            out_func3    <= inst[14:12];
            out_func7    <= inst[31:25];
            out_rs1_data <= rs1_val;
            out_rs2_data <= rs2_val;
            out_imm      <= imm;
            out_pc       <= in_pc;
            out_illegal  <= illegal;
            hold_rs1     <= rs1;
            hold_rs2     <= rs2;
        end else if (flush || !out_valid || out_ready) begin
            out_valid  <= 1'b0;
            out_opcode <= NOP_OPCODE;
        end else begin
            // Stalled bundle: keep operands current with writebacks to its sources.
            if (wb_hit && wb_rd == hold_rs1)
                out_rs1_data <= wb_data;
            if (wb_hit && wb_rd == hold_rs2)
                out_rs2_data <= wb_data;
        end
    end
endmodule

// File: tb/tb_id_stage_param.sv
// tb_id_stage_param: directed vector bench for id_stage_param (XLEN=64/32 regs and XLEN=32/16 regs).
module tb_id_stage_param;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, wb_en;
    logic [31:0] inst;
    logic [63:0] in_pc, wb_data;
    logic [4:0]  wb_rd, dbg_raddr;

    logic        in_ready, out_valid, out_illegal;
    logic [6:0]  out_opcode, out_func7;
    logic [4:0]  out_rd;
    logic [2:0]  out_func3;
    logic [63:0] out_rs1_data, out_rs2_data, out_imm, out_pc, dbg_rdata;

    logic        s_in_ready, s_out_valid, s_out_illegal;
    logic [6:0]  s_out_opcode, s_out_func7;
    logic [4:0]  s_out_rd;
    logic [2:0]  s_out_func3;
    logic [31:0] s_out_rs1_data, s_out_rs2_data, s_out_imm, s_out_pc, s_dbg_rdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    id_stage_param dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_func3(out_func3), .out_func7(out_func7),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
        .out_pc(out_pc), .out_illegal(out_illegal), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    id_stage_param #(.XLEN(32), .NUM_REGS(16)) dut_s (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .inst(inst), .in_pc(in_pc[31:0]), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_opcode(s_out_opcode), .out_rd(s_out_rd), .out_func3(s_out_func3),
        .out_func7(s_out_func7), .out_rs1_data(s_out_rs1_data), .out_rs2_data(s_out_rs2_data),
        .out_imm(s_out_imm), .out_pc(s_out_pc), .out_illegal(s_out_illegal), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data[31:0]), .dbg_raddr(dbg_raddr), .dbg_rdata(s_dbg_rdata)
    );

    typedef struct {
        logic [31:0] inst;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        ill;
        logic        ill16;
        logic        c1;
        logic [63:0] rs1;
        logic        c2;
        logic [63:0] rs2;
    } vec_t;

    vec_t v[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wb(input logic [4:0] r, input logic [63:0] d);
        wb_en = 1'b1;
        wb_rd = r;
        wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        v[0]  = '{32'hFE000EE3, 7'h63, 5'd29, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1, 64'h0, 1, 64'h0};
        v[1]  = '{32'h00812383, 7'h03, 5'd7, 3'd2, 7'h00, 64'h8, 0, 0, 1, 64'h1111, 0, 64'h0};
        v[2]  = '{32'hFFF50293, 7'h13, 5'd5, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 64'h2222, 0, 64'h0};
        v[3]  = '{32'hFE312C23, 7'h23, 5'd24, 3'd2, 7'h7F, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 64'h1111, 1, 64'hABCD};
        v[4]  = '{32'h80000337, 7'h37, 5'd6, 3'd0, 7'h40, 64'hFFFF_FFFF_8000_0000, 0, 0, 0, 64'h0, 0, 64'h0};
        v[5]  = '{32'h001000EF, 7'h6F, 5'd1, 3'd0, 7'h00, 64'h800, 0, 0, 0, 64'h0, 0, 64'h0};
        v[6]  = '{32'h12345497, 7'h17, 5'd9, 3'd5, 7'h09, 64'h1234_5000, 0, 0, 0, 64'h0, 0, 64'h0};
        v[7]  = '{32'h0000007F, 7'h7F, 5'd0, 3'd0, 7'h00, 64'h0, 1, 1, 0, 64'h0, 0, 64'h0};
        v[8]  = '{32'h003100BB, 7'h3B, 5'd1, 3'd0, 7'h00, 64'h0, 0, 1, 1, 64'h1111, 1, 64'hABCD};
        v[9]  = '{32'h40A10233, 7'h33, 5'd4, 3'd0, 7'h20, 64'h0, 0, 0, 1, 64'h1111, 1, 64'h2222};
        v[10] = '{32'h003108B3, 7'h33, 5'd17, 3'd0, 7'h00, 64'h0, 0, 1, 1, 64'h1111, 1, 64'hABCD};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; wb_en = 1'b0;
        inst = 32'h0; in_pc = 64'h0; wb_data = 64'h0; wb_rd = 5'd0; dbg_raddr = 5'd5;
        tick();
        tick();
        chk("rst out_valid", out_valid, 0);
        chk("rst out_opcode", out_opcode, 7'h13);
        chk("rst out_imm", out_imm, 0);
        chk("rst out_pc", out_pc, 0);
        chk("rst dbg x5", dbg_rdata, 0);
        chk("rst small opcode", s_out_opcode, 7'h13);
        rst = 1'b0;

        inst = 32'h00500093; in_pc = 64'h100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("addi out_valid", out_valid, 1);
        chk("addi out_opcode", out_opcode, 7'h13);
        chk("addi out_rd", out_rd, 1);
        chk("addi out_imm", out_imm, 5);
        chk("addi out_rs1", out_rs1_data, 0);
        chk("addi out_pc", out_pc, 64'h100);

        wb(5'd2, 64'h1111);
        chk("consumed out_valid", out_valid, 0);
        chk("consumed out_opcode", out_opcode, 7'h13);
        dbg_raddr = 5'd2; #1;
        chk("dbg x2", dbg_rdata, 64'h1111);
        wb_en = 1'b1; wb_rd = 5'd10; wb_data = 64'h2222; dbg_raddr = 5'd10; #1;
        chk("dbg bypass x10", dbg_rdata, 64'h2222);
        tick();
        wb_en = 1'b0; #1;
        chk("dbg stored x10", dbg_rdata, 64'h2222);
        wb(5'd0, 64'hDEAD);
        dbg_raddr = 5'd0; #1;
        chk("dbg x0", dbg_rdata, 0);
        wb(5'd20, 64'h5A);
        dbg_raddr = 5'd20; #1;
        chk("dbg x20", dbg_rdata, 64'h5A);
        chk("small dbg x20", s_dbg_rdata, 0);

        inst = 32'h00318233; in_valid = 1'b1; wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'hABCD;
        tick();
        wb_en = 1'b0;
        chk("bypass rs1", out_rs1_data, 64'hABCD);
        chk("bypass rs2", out_rs2_data, 64'hABCD);
        chk("bypass rd", out_rd, 4);

        for (int i = 0; i < 11; i++) begin
            inst = v[i].inst;
            in_pc = 64'h1000 + 64'(i * 4);
            in_valid = 1'b1;
            tick();
            chk($sformatf("v%0d valid", i), out_valid, 1);
            chk($sformatf("v%0d opcode", i), out_opcode, v[i].op);
            chk($sformatf("v%0d rd", i), out_rd, v[i].rd);
            chk($sformatf("v%0d func3", i), out_func3, v[i].f3);
            chk($sformatf("v%0d func7", i), out_func7, v[i].f7);
            chk($sformatf("v%0d imm", i), out_imm, v[i].imm);
            chk($sformatf("v%0d pc", i), out_pc, 64'h1000 + 64'(i * 4));
            chk($sformatf("v%0d illegal", i), out_illegal, v[i].ill);
            chk($sformatf("v%0d small illegal", i), s_out_illegal, v[i].ill16);
            chk($sformatf("v%0d small imm", i), s_out_imm, v[i].imm[31:0]);
            if (v[i].c1)
                chk($sformatf("v%0d rs1", i), out_rs1_data, v[i].rs1);
            if (v[i].c2)
                chk($sformatf("v%0d rs2", i), out_rs2_data, v[i].rs2);
        end

        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush idle out_valid", out_valid, 0);

        inst = 32'h000302B3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; inst = 32'h00000013; #1;
        chk("hold in_ready", in_ready, 0);
        wb_en = 1'b1; wb_rd = 5'd6; wb_data = 64'h77;
        tick();
        wb_en = 1'b0;
        chk("refresh rs1", out_rs1_data, 64'h77);
        chk("refresh rs2", out_rs2_data, 0);
        chk("refresh rd", out_rd, 5);
        chk("refresh opcode", out_opcode, 7'h33);
        chk("refresh valid", out_valid, 1);
        chk("refresh in_ready", in_ready, 0);
        wb(5'd9, 64'h55);
        chk("no refresh rs1", out_rs1_data, 64'h77);
        chk("no refresh rd", out_rd, 5);

        flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd12; wb_data = 64'h99; #1;
        chk("flush in_ready", in_ready, 0);
        tick();
        flush = 1'b0; wb_en = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", out_valid, 0);
        chk("flush out_opcode", out_opcode, 7'h13);
        dbg_raddr = 5'd12; #1;
        chk("flush wb x12", dbg_rdata, 64'h99);

        out_ready = 1'b1; inst = 32'h00812383; in_valid = 1'b1;
        tick();
        inst = 32'h00038433; #1;
`ifdef ID_SCOREBOARD_EN
        chk("sb stall in_ready", in_ready, 0);
        tick();
        chk("sb stall2 in_ready", in_ready, 0);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'h3C3C; #1;
        chk("sb release in_ready", in_ready, 1);
`else
        chk("nosb in_ready", in_ready, 1);
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'h3C3C;
`endif
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
        chk("hazard out_valid", out_valid, 1);
        chk("hazard out_rd", out_rd, 8);
        chk("hazard rs1", out_rs1_data, 64'h3C3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
